// File: rtl/le_serial_driver_pkg.sv
// Shared constants for the bit-serial logic-element driver: FSM encodings
// and the slice function-select codes.
package le_serial_driver_pkg;

    localparam logic [1:0] LE_IDLE  = 2'd0;
    localparam logic [1:0] LE_SHIFT = 2'd1;
    localparam logic [1:0] LE_DONE  = 2'd2;

    localparam logic [1:0] LE_S_NOTA = 2'b00;
    localparam logic [1:0] LE_S_AND  = 2'b01;
    localparam logic [1:0] LE_S_PASS = 2'b10;
    localparam logic [1:0] LE_S_OR   = 2'b11;

endpackage

// File: rtl/le_serial_driver_bit_shifter.sv
// Loadable right shift register: parallel load, serial-in at the MSB,
// parallel-out. Load takes priority over shift.
module le_serial_driver_bit_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/le_serial_driver.sv
// Bit-serial sequencer: feeds operand bit pairs LSB first to an external
// 1-bit logic-element slice and assembles its WIDTH-bit result.
module le_serial_driver
    import le_serial_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_m,
    input  logic [1:0]       cmd_s,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_x,
    output logic             rsp_zero,
    output logic             busy,
    output logic             le_m,
    output logic [1:0]       le_s,
    output logic             le_a,
    output logic             le_b,
    input  logic             le_x
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_le_m;
    logic [1:0]       r_le_s;
    logic [WIDTH-1:0] r_rsp_x;
    logic             r_rsp_zero;

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_res_q;
    logic [WIDTH-1:0] w_result;
    logic             w_unused;

    assign w_accept = (r_state == LE_IDLE) && cmd_valid;
    assign w_shift  = (r_state == LE_SHIFT);
    assign w_last   = w_shift && (r_cnt == LAST_BIT);
    // Final sample is merged combinationally so the result is captured on the exit edge.
    assign w_result = {le_x, w_res_q[WIDTH-1:1]};
    assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1], w_res_q[0]};

    le_serial_driver_bit_shifter #(.W(WIDTH)) u_a_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (cmd_a),
        .i_shift    (w_shift),
        .i_sin      (1'b0),
        .o_q        (w_a_q)
    );

    le_serial_driver_bit_shifter #(.W(WIDTH)) u_b_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (cmd_b),
        .i_shift    (w_shift),
        .i_sin      (1'b0),
        .o_q        (w_b_q)
    );

    le_serial_driver_bit_shifter #(.W(WIDTH)) u_res_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val ({WIDTH{1'b0}}),
        .i_shift    (w_shift),
        .i_sin      (le_x),
        .o_q        (w_res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LE_IDLE;
            r_cnt      <= '0;
            r_le_m     <= 1'b0;
            r_le_s     <= 2'b00;
            r_rsp_x    <= '0;
            r_rsp_zero <= 1'b1;
        end else begin
            case (r_state)
                LE_IDLE: begin
                    if (cmd_valid) begin
                        r_le_m  <= cmd_m;
                        r_le_s  <= cmd_s;
                        r_cnt   <= '0;
                        r_state <= LE_SHIFT;
                    end
                end
                LE_SHIFT: begin
                    if (w_last) begin
                        r_rsp_x    <= w_result;
                        r_rsp_zero <= (w_result == '0);
                        r_state    <= LE_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LE_DONE: begin
                    if (rsp_ready) begin
                        r_state <= LE_IDLE;
                    end
                end
                default: r_state <= LE_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == LE_IDLE);
    assign busy      = (r_state != LE_IDLE);
    assign rsp_valid = (r_state == LE_DONE);
    assign rsp_x     = r_rsp_x;
    assign rsp_zero  = r_rsp_zero;
    assign le_m      = r_le_m;
    assign le_s      = r_le_s;
    assign le_a      = w_shift & w_a_q[0];
    assign le_b      = w_shift & w_b_q[0];

endmodule

// File: tb/tb_le_serial_driver.sv
// Bench for le_serial_driver: behavioural slice, word-level golden model,
// directed scenarios and 200 random back-to-back commands.
module tb_le_serial_driver;
    import le_serial_driver_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_m = 1'b0;
    logic [1:0]   cmd_s = 2'b00;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_x;
    logic         rsp_zero;
    logic         busy;
    logic         le_m;
    logic [1:0]   le_s;
    logic         le_a;
    logic         le_b;
    logic         le_x;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [W-1:0] seen_a;
    logic [W-1:0] seen_b;

    le_serial_driver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_m     (cmd_m),
        .cmd_s     (cmd_s),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .le_m      (le_m),
        .le_s      (le_s),
        .le_a      (le_a),
        .le_b      (le_b),
        .le_x      (le_x)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 1-bit slice, purely combinational.
    always_comb begin
        le_x = le_a;
        if (!le_m) begin
            case (le_s)
                LE_S_NOTA: le_x = ~le_a;
                LE_S_AND:  le_x = le_a & le_b;
                LE_S_PASS: le_x = le_a;
                LE_S_OR:   le_x = le_a | le_b;
                default:   le_x = 1'bx;
            endcase
        end
    end

    function automatic logic [W-1:0] model(input logic m, input logic [1:0] s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (m) r = a;
        else if (s == 2'b00) r = ~a;
        else if (s == 2'b01) r = a & b;
        else if (s == 2'b10) r = a;
        else r = a | b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of SHIFT cycle 1.
    task automatic send_cmd(input logic m, input logic [1:0] s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit hold, output int acc);
        int k;
        k = 0;
        cmd_m = m; cmd_s = s; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready", cmd_ready, 1);
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Counts cycles after acceptance until rsp_valid, recording the slice operand bits.
    task automatic wait_rsp();
        int k;
        k = 1;
        seen_a = '0;
        seen_b = '0;
        while (!rsp_valid && k < 40) begin
            if (k <= W) begin
                seen_a[k-1] = le_a;
                seen_b[k-1] = le_b;
            end
            @(negedge clk);
            k++;
        end
        chk("latency", k, W + 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic m, input logic [1:0] s,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp);
        int acc;
        send_cmd(m, s, a, b, 1'b0, acc);
        wait_rsp();
        chk({tag, "_x"}, rsp_x, exp);
        chk({tag, "_zero"}, rsp_zero, (exp == '0));
        take_rsp();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_x"}, rsp_x, 0);
        chk({tag, "_rsp_zero"}, rsp_zero, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_le"}, {le_m, le_s, le_a, le_b}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        bit saw_valid;
        logic m;
        logic [1:0] s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");

        run_check("and",   1'b0, 2'b01, 8'hA5, 8'h3C, 8'h24);
        run_check("or",    1'b0, 2'b11, 8'hA5, 8'h3C, 8'hBD);
        run_check("nota",  1'b0, 2'b00, 8'hA5, 8'h3C, 8'h5A);
        run_check("pass",  1'b0, 2'b10, 8'hA5, 8'h3C, 8'hA5);
        run_check("mpass", 1'b1, 2'b01, 8'h00, 8'hFF, 8'h00);

        send_cmd(1'b0, 2'b11, 8'h01, 8'h80, 1'b0, acc);
        wait_rsp();
        chk("le_a_order", seen_a, 8'h01);
        chk("le_b_order", seen_b, 8'h80);
        take_rsp();

        // Stall in DONE with a second command waiting.
        send_cmd(1'b0, 2'b01, 8'hF0, 8'h3C, 1'b0, acc);
        wait_rsp();
        cmd_m = 1'b0; cmd_s = 2'b11; cmd_a = 8'h0F; cmd_b = 8'hF0; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("stall_x", rsp_x, 8'h30);
            chk("stall_ready", cmd_ready, 0);
            chk("stall_valid", rsp_valid, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_reentered", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("second_accepted", busy, 1);
        wait_rsp();
        chk("second_x", rsp_x, 8'hFF);
        chk("second_zero", rsp_zero, 0);
        take_rsp();

        // Reset during SHIFT cycle 4.
        send_cmd(1'b1, 2'b11, 8'h5A, 8'hC3, 1'b0, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        saw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        chk("abort_no_rsp", saw_valid, 0);
        run_check("after_abort", 1'b0, 2'b01, 8'hA5, 8'h3C, 8'h24);

        // Back-to-back random commands with rsp_ready held high.
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            m = ($urandom_range(0, 3) == 0);
            s = 2'($urandom_range(0, 3));
            a = W'($urandom);
            b = W'($urandom);
            exp = model(m, s, a, b);
            send_cmd(m, s, a, b, 1'b1, acc);
            if (i > 0) chk("spacing", acc - prev, W + 2);
            prev = acc;
            wait_rsp();
            chk("rand_x", rsp_x, exp);
            chk("rand_zero", rsp_zero, (exp == '0));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
